// File: rtl/status_pkg.sv
// Shared types for the status monitor slice.
// Status codes, FSM states and default limits.
package status_pkg;

  localparam int CODE_W        = 2;
  localparam int MAX_CYCLE_DEF = 120000;

  typedef enum logic [1:0] {
    R_TYPE       = 2'd0,
    I_TYPE       = 2'd1,
    INVALID_TYPE = 2'd2,
    EOF_TYPE     = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_terminal(
    logic [CODE_W-1:0] s
  );
    return (s == INVALID_TYPE) ||
           (s == EOF_TYPE);
  endfunction

endpackage

// File: rtl/status_exp_ram.sv
// Expected-status table: sync write, async read.
// Ports: clk, we/waddr/wdata write side, raddr/rdata read side.
module status_exp_ram
  import status_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [CODE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [CODE_W-1:0] rdata
);

  logic [CODE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/status_monitor.sv
// Compares a core's status stream with a preloaded expected table.
// Ports: i_clk/i_rst, i_exp_* table load, i_start, i_status(_valid), o_* results.
module status_monitor
  import status_pkg::*;
#(
  parameter int EXP_DEPTH = 1024,
  parameter int EXP_AW    = 10,
  parameter int MAX_CYCLE = MAX_CYCLE_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_exp_we,
  input  logic [EXP_AW-1:0] i_exp_addr,
  input  logic [1:0]        i_exp_data,
  input  logic              i_start,
  input  logic [1:0]        i_status,
  input  logic              i_status_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_timeout,
  output logic              o_proto_err,
  output logic [15:0]       o_status_cnt,
  output logic [15:0]       o_err_cnt,
  output logic [EXP_AW-1:0] o_first_err_idx
);

  localparam int CW = $clog2(MAX_CYCLE + 1);

  state_e state_q, state_d;

  logic [EXP_AW-1:0] idx_q;
  logic [CW-1:0]     cyc_q;
  logic [15:0]       cnt_q;
  logic [15:0]       err_q;
  logic [EXP_AW-1:0] first_q;
  logic              tmo_q;
  logic              proto_q;
  logic              exh_q;

  logic        run;
  logic        sample;
  logic        last_cyc;
  logic        mism;
  logic        start_run;
  logic [1:0]  exp_rd;

  status_exp_ram #(
    .DEPTH (EXP_DEPTH),
    .AW    (EXP_AW)
  ) u_ram (
    .clk   (i_clk),
    .we    (i_exp_we && !run),
    .waddr (i_exp_addr),
    .wdata (i_exp_data),
    .raddr (idx_q),
    .rdata (exp_rd)
  );

  assign run      = (state_q == S_RUN);
  assign sample   = run && i_status_valid;
  assign last_cyc = (cyc_q == CW'(MAX_CYCLE - 1));
  // once the last table slot is used, every
  // further status is an overrun mismatch
  assign mism     = exh_q || (i_status != exp_rd);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d   = S_RUN;
          start_run = 1'b1;
        end
      end
      S_RUN: begin
        if ((sample && is_terminal(i_status)) ||
            last_cyc) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || start_run) begin
      idx_q   <= '0;
      cyc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      tmo_q   <= 1'b0;
      proto_q <= 1'b0;
      exh_q   <= 1'b0;
    end else if (run) begin
      cyc_q <= cyc_q + 1'b1;
      if (last_cyc) begin
        tmo_q <= 1'b1;
      end
      if (i_status_valid) begin
        cnt_q <= cnt_q + 16'd1;
        if (mism) begin
          if (err_q != 16'hFFFF) begin
            err_q <= err_q + 16'd1;
          end
          if (err_q == 16'd0) begin
            first_q <= idx_q;
          end
        end
        if (exh_q) begin
          proto_q <= 1'b1;
        end else if (idx_q ==
                     EXP_AW'(EXP_DEPTH - 1)) begin
          exh_q <= 1'b1;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end else if (i_status_valid) begin
      proto_q <= 1'b1;
    end
  end

  assign o_busy          = run;
  assign o_done          = (state_q == S_DONE);
  assign o_timeout       = tmo_q;
  assign o_proto_err     = proto_q;
  assign o_status_cnt    = cnt_q;
  assign o_err_cnt       = err_q;
  assign o_first_err_idx = first_q;
  assign o_pass          = o_done &&
                           (err_q == 16'd0) &&
                           !tmo_q && !proto_q;

endmodule
